mask_gen_vga_seq: RTL and testbench
===================================

Name: mask_gen_vga_seq

Overview:
- Sequencer for the VGA mask generator (mask_generation_VGA).
- Accepts one mask configuration per frame over a valid/ready handshake, resets the generator, and serially loads the pattern.
- Paces row generation against a downstream row consumer and detects frame completion per mask type: repeated, sliding right/left, random.
- Sits between the register/config interface and the mask generator; the row output feeds the VGA row buffer.

Parameters:
- FRAME_ROWS, 480, rows per frame for random mode.
- MAX_ROWS, 640, sliding-mode row timeout (one full 640-bit traversal).
- PAT_LEN, 32, serial pattern bits loaded for sliding/random modes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  config offered
- cfg_ready  out  1  sequencer idle, accepts config
- cfg_mask_type  in  2  00 slide right, 01 slide left, 10 random, 11 repeated
- cfg_pattern_w  in  5  pattern width passed to generator
- cfg_repeated_pattern  in  8  repeated-mode pattern
- cfg_pattern  in  32  serial pattern; bit 0 shifted first
- abort  in  1  terminate current frame
- row_ready  in  1  consumer can take a row this cycle
- mg_rst_n  out  1  generator reset, active low
- mg_clk_en  out  1  generator clock enable
- mg_load_pattern  out  1  generator load strobe
- mg_pattern  out  1  serial pattern bit
- mg_mask_type  out  2  registered cfg_mask_type
- mg_pattern_w  out  5  registered cfg_pattern_w
- mg_repeated_pattern  out  8  registered cfg_repeated_pattern
- mg_mask  in  640 ([0:639])  generator row output
- mg_rp_valid  in  1  generator row valid
- row_valid  out  1  row accepted by consumer (mg_rp_valid & row_ready & RUN)
- row_index  out  10  index of the current accepted row
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on frame end
- timeout  out  1  one-cycle pulse, sliding frame hit MAX_ROWS without wrap

Behaviour:
- Reset values: state IDLE; cfg_ready=1; mg_rst_n=0; mg_clk_en=0; mg_load_pattern=0; mg_pattern=0; all mg_* config=0; row_index=0; row_valid=busy=frame_done=timeout=0. mg_rst_n deasserts on the first IDLE cycle after rst falls.
- IDLE:
  - cfg_ready=1, mg_clk_en=1.
  - On cfg_valid: register cfg_* (config and init pattern {cfg_pattern reversed, 608'b0}), go to GRST.
- GRST: mg_rst_n=0 for exactly 1 cycle, then go to LOAD.
- LOAD:
  - Type 11: mg_load_pattern=1 for 1 cycle.
  - Otherwise: PAT_LEN consecutive cycles with mg_load_pattern=1 and mg_pattern=pattern[k], k=0..31 ascending (5-bit counter).
  - Then go to RUN with row_index=0.
- RUN:
  - mg_clk_en=row_ready, so the generator stalls while the consumer is busy.
  - A row is accepted when mg_rp_valid & row_ready; row_valid is combinational with it.
  - row_index increments after each accepted row and saturates at 1023.
- Completion (evaluated on the accepted row):
  - Type 11: first accepted row.
  - Type 10: accepted row with row_index==FRAME_ROWS-1, i.e. exactly FRAME_ROWS rows.
  - Type 00/01: mg_mask equals the init pattern on any row with row_index>=1 (row 0 is never compared). If no match by row_index==MAX_ROWS-1, pulse timeout together with frame_done.
  - On completion go to DONE.
- DONE: frame_done=1 for 1 cycle, mg_clk_en=0, then go to IDLE.
- abort in GRST/LOAD/RUN: go to DONE on the next edge; frame_done pulses, timeout stays 0, no row_valid in the abort cycle.
- Simultaneous abort and completion: completion wins, so row_valid and the final row are reported.
- cfg_valid outside IDLE is ignored (cfg_ready=0), and config is held stable for the whole frame.
- rst mid-frame returns all outputs to reset values immediately (asynchronous).

Decomposition:
- Package mask_gen_vga_pkg holds:
  - mask_type_e (SLIDE_R, SLIDE_L, RANDOM, REPEAT)
  - seq_state_e (IDLE, GRST, LOAD, RUN, DONE)
  - constants VGA_W=640, VGA_H=480
  - mask_cfg_t struct (type, pattern_w, repeated, pattern)
- Sub-module mask_gen_vga_loader: serial pattern shifter and bit counter, with start/busy/done handshake; the FSM and row counter stay in the top module.

Test Plan:
- cfg type 11, repeated 8'hAF, row_ready=1: mg_load_pattern high exactly 1 cycle; frame_done 1 cycle after the first mg_rp_valid; exactly 1 row_valid.
- cfg type 00, pattern 32'h03D0A052: 32 load cycles with mg_pattern sequence = bits 0..31 (0,1,0,0,1,0,1,0,...); frame_done on the first row_index>=1 matching the init pattern; timeout=0.
- cfg type 10, row_ready toggling 1/0 each cycle: exactly 480 row_valid pulses; mg_clk_en mirrors row_ready in RUN; frame_done after row_index 479.
- Sliding with a stub generator that never wraps: timeout and frame_done pulse together on row 639; cfg_ready returns the next cycle.
- abort at LOAD cycle 10, then a new cfg type 11: no further mg_load_pattern bits, frame_done pulse, then a clean second frame starting with a 1-cycle mg_rst_n=0.
- rst asserted mid-RUN for 2 cycles: all outputs at reset values asynchronously; cfg_valid during rst is ignored; IDLE resumes afterward.

Source files
------------

// File: rtl/mask_gen_vga_pkg.sv
`default_nettype none
// ============================================================================
// mask_gen_vga_pkg : shared types and constants for the VGA mask sequencer
// Rev 1.0
// ============================================================================
package mask_gen_vga_pkg;

    localparam int VGA_W = 640;
    localparam int VGA_H = 480;

    typedef enum logic [1:0] {
        SLIDE_R = 2'b00,
        SLIDE_L = 2'b01,
        RANDOM  = 2'b10,
        REPEAT  = 2'b11
    } mask_type_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GRST = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    typedef struct packed {
        mask_type_e  mtype;
        logic [4:0]  pattern_w;
        logic [7:0]  repeated;
        logic [31:0] pattern;
    } mask_cfg_t;

    // Row the generator shows once a sliding pattern has wrapped: pattern bit k at column k.
    function automatic logic [0:VGA_W-1] init_mask(input logic [31:0] pattern);
        logic [0:VGA_W-1] m;
        m = '0;
        for (int k = 0; k < 32; k++) begin
            m[k] = pattern[k];
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mask_gen_vga_seq_if.sv
`default_nettype none
// ============================================================================
// mask_gen_vga_seq_if : config, generator and row-consumer signals of the sequencer
// Rev 1.0
// ============================================================================
interface mask_gen_vga_seq_if;
    import mask_gen_vga_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [1:0]          cfg_mask_type;
    logic [4:0]          cfg_pattern_w;
    logic [7:0]          cfg_repeated_pattern;
    logic [31:0]         cfg_pattern;
    logic                abort;
    logic                row_ready;
    logic                mg_rst_n;
    logic                mg_clk_en;
    logic                mg_load_pattern;
    logic                mg_pattern;
    logic [1:0]          mg_mask_type;
    logic [4:0]          mg_pattern_w;
    logic [7:0]          mg_repeated_pattern;
    logic [0:VGA_W-1]    mg_mask;
    logic                mg_rp_valid;
    logic                row_valid;
    logic [9:0]          row_index;
    logic                busy;
    logic                frame_done;
    logic                timeout;

    modport slave (
        input  cfg_valid, cfg_mask_type, cfg_pattern_w, cfg_repeated_pattern, cfg_pattern,
        input  abort, row_ready, mg_mask, mg_rp_valid,
        output cfg_ready, mg_rst_n, mg_clk_en, mg_load_pattern, mg_pattern,
        output mg_mask_type, mg_pattern_w, mg_repeated_pattern,
        output row_valid, row_index, busy, frame_done, timeout
    );

    modport master (
        output cfg_valid, cfg_mask_type, cfg_pattern_w, cfg_repeated_pattern, cfg_pattern,
        output abort, row_ready, mg_mask, mg_rp_valid,
        input  cfg_ready, mg_rst_n, mg_clk_en, mg_load_pattern, mg_pattern,
        input  mg_mask_type, mg_pattern_w, mg_repeated_pattern,
        input  row_valid, row_index, busy, frame_done, timeout
    );

endinterface
`default_nettype wire

// File: rtl/mask_gen_vga_loader.sv
`default_nettype none
// ============================================================================
// mask_gen_vga_loader : shifts the serial pattern out LSB first, one bit per cycle
// Rev 1.0
// ============================================================================
module mask_gen_vga_loader #(
    parameter int PAT_LEN = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic               clear,
    input  wire logic [PAT_LEN-1:0] pattern,
    output logic                    busy,
    output logic                    done,
    output logic                    pat_bit
);

    localparam int CNT_W = $clog2(PAT_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAT_LEN - 1);

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [PAT_LEN-1:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (clear) begin
            r_busy  <= 1'b0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_shift <= pattern;
        end else if (r_busy) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == LAST);
    assign pat_bit = r_busy & r_shift[0];

endmodule
`default_nettype wire

// File: rtl/mask_gen_vga_seq.sv
`default_nettype none
// ============================================================================
// mask_gen_vga_seq : per-frame sequencer (reset, pattern load, row pacing, frame end)
// Rev 1.0
// ============================================================================
module mask_gen_vga_seq
    import mask_gen_vga_pkg::*;
#(
    parameter int FRAME_ROWS = 480,
    parameter int MAX_ROWS   = 640,
    parameter int PAT_LEN    = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mask_gen_vga_seq_if.slave bus
);

    seq_state_e       r_state;
    seq_state_e       w_next;
    mask_cfg_t        r_cfg;
    logic [9:0]       r_row_index;
    logic             r_timeout;
    logic [0:VGA_W-1] w_init;
    logic             w_accept;
    logic             w_match;
    logic             w_last;
    logic             w_complete;
    logic             w_timeout_hit;
    logic             w_ld_start;
    logic             w_ld_busy;
    logic             w_ld_done;
    logic             w_ld_bit;

    mask_gen_vga_loader #(.PAT_LEN(PAT_LEN)) u_loader (
        .clk     (clk),
        .rst     (rst),
        .start   (w_ld_start),
        .clear   (bus.abort),
        .pattern (r_cfg.pattern),
        .busy    (w_ld_busy),
        .done    (w_ld_done),
        .pat_bit (w_ld_bit)
    );

    assign w_init   = init_mask(r_cfg.pattern);
    assign w_accept = (r_state == RUN) && bus.mg_rp_valid && bus.row_ready;
    // Row 0 still shows the freshly loaded pattern, so only later rows count as a wrap.
    assign w_match  = (r_row_index != 10'd0) && (bus.mg_mask == w_init);
    assign w_last   = (r_row_index == 10'(MAX_ROWS - 1));

    always_comb begin
        w_complete    = 1'b0;
        w_timeout_hit = 1'b0;
        if (w_accept) begin
            unique case (r_cfg.mtype)
                REPEAT:  w_complete = 1'b1;
                RANDOM:  w_complete = (r_row_index == 10'(FRAME_ROWS - 1));
                default: begin
                    w_complete    = w_match || w_last;
                    w_timeout_hit = !w_match && w_last;
                end
            endcase
        end
    end

    always_comb begin
        w_next              = r_state;
        w_ld_start          = 1'b0;
        bus.cfg_ready       = 1'b0;
        bus.mg_clk_en       = 1'b0;
        bus.mg_rst_n        = 1'b1;
        bus.mg_load_pattern = 1'b0;
        bus.mg_pattern      = 1'b0;
        bus.row_valid       = 1'b0;
        bus.frame_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                bus.mg_clk_en = 1'b1;
                if (bus.cfg_valid) w_next = GRST;
            end
            GRST: begin
                bus.mg_rst_n  = 1'b0;
                bus.mg_clk_en = 1'b1;
                if (bus.abort) begin
                    w_next = DONE;
                end else begin
                    w_next     = LOAD;
                    w_ld_start = (r_cfg.mtype != REPEAT);
                end
            end
            LOAD: begin
                bus.mg_clk_en = 1'b1;
                if (r_cfg.mtype == REPEAT) begin
                    bus.mg_load_pattern = !bus.abort;
                    w_next              = bus.abort ? DONE : RUN;
                end else begin
                    bus.mg_load_pattern = w_ld_busy && !bus.abort;
                    bus.mg_pattern      = w_ld_bit && !bus.abort;
                    if (bus.abort)      w_next = DONE;
                    else if (w_ld_done) w_next = RUN;
                end
            end
            RUN: begin
                bus.mg_clk_en = bus.row_ready;
                // A completing row is still reported when abort arrives in the same cycle.
                bus.row_valid = w_accept && (w_complete || !bus.abort);
                if (w_complete || bus.abort) w_next = DONE;
            end
            DONE: begin
                bus.frame_done = 1'b1;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            bus.mg_clk_en = 1'b0;
            bus.mg_rst_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cfg       <= '0;
            r_row_index <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_timeout_hit;
            if (r_state == IDLE && bus.cfg_valid) begin
                r_cfg.mtype     <= mask_type_e'(bus.cfg_mask_type);
                r_cfg.pattern_w <= bus.cfg_pattern_w;
                r_cfg.repeated  <= bus.cfg_repeated_pattern;
                r_cfg.pattern   <= bus.cfg_pattern;
            end
            if (r_state == LOAD) begin
                r_row_index <= '0;
            end else if (bus.row_valid && r_row_index != 10'h3FF) begin
                r_row_index <= r_row_index + 10'd1;
            end
        end
    end

    assign bus.mg_mask_type        = r_cfg.mtype;
    assign bus.mg_pattern_w        = r_cfg.pattern_w;
    assign bus.mg_repeated_pattern = r_cfg.repeated;
    assign bus.row_index           = r_row_index;
    assign bus.busy                = (r_state != IDLE);
    assign bus.timeout             = (r_state == DONE) && r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mask_gen_vga_seq.sv
`default_nettype none
// ============================================================================
// tb_mask_gen_vga_seq : randomized frames against a frame-level reference model
// Rev 1.0
// ============================================================================
module tb_mask_gen_vga_seq;
    import mask_gen_vga_pkg::*;

    localparam int FRAME_ROWS = 480;
    localparam int MAX_ROWS   = 640;
    localparam int PAT_LEN    = 32;
    localparam int RUN_BUDGET = 4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mask_gen_vga_seq_if bus ();

    mask_gen_vga_seq #(
        .FRAME_ROWS (FRAME_ROWS),
        .MAX_ROWS   (MAX_ROWS),
        .PAT_LEN    (PAT_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [0:639] model_init(input logic [31:0] p);
        logic [31:0] r;
        r = {<<{p}};
        return {r, 608'b0};
    endfunction

    task automatic check_reset(input string p);
        check({p, "_cfg_ready"},  bus.cfg_ready, 1);
        check({p, "_mg_rst_n"},   bus.mg_rst_n, 0);
        check({p, "_mg_clk_en"},  bus.mg_clk_en, 0);
        check({p, "_load"},       bus.mg_load_pattern, 0);
        check({p, "_pattern"},    bus.mg_pattern, 0);
        check({p, "_mask_type"},  bus.mg_mask_type, 0);
        check({p, "_pattern_w"},  bus.mg_pattern_w, 0);
        check({p, "_repeated"},   bus.mg_repeated_pattern, 0);
        check({p, "_row_index"},  bus.row_index, 0);
        check({p, "_row_valid"},  bus.row_valid, 0);
        check({p, "_busy"},       bus.busy, 0);
        check({p, "_frame_done"}, bus.frame_done, 0);
        check({p, "_timeout"},    bus.timeout, 0);
    endtask

    // One full frame. match_row: accepted row on which the stub shows the wrapped pattern
    // (-1 never); abort_load / abort_row: where abort is raised (-1 never).
    task automatic do_frame(input logic [1:0] mt, input logic [31:0] pat, input logic [7:0] rep,
                            input logic [4:0] pw, input int rr_mode, input int match_row,
                            input int abort_load, input int abort_row);
        logic [0:639] init;
        logic [0:639] mask;
        int  nrows, nvalid, nload;
        bit  aborted, done_run, exp_to, acc, comp, rp, rr, ab, sliding;
        init     = model_init(pat);
        sliding  = (mt == 2'b00 || mt == 2'b01);
        aborted  = 0;
        exp_to   = 0;
        nvalid   = 0;

        tick();
        bus.cfg_valid = 1; bus.cfg_mask_type = mt; bus.cfg_pattern = pat;
        bus.cfg_repeated_pattern = rep; bus.cfg_pattern_w = pw;
        bus.mg_rp_valid = 0; bus.abort = 0;
        settle();
        check("idle_cfg_ready", bus.cfg_ready, 1);
        check("idle_clk_en", bus.mg_clk_en, 1);
        check("idle_busy", bus.busy, 0);

        tick();
        bus.cfg_mask_type = 2'($urandom); bus.cfg_pattern = $urandom;
        bus.cfg_repeated_pattern = 8'($urandom); bus.cfg_pattern_w = 5'($urandom);
        settle();
        check("grst_rst_n", bus.mg_rst_n, 0);
        check("grst_busy", bus.busy, 1);
        check("grst_cfg_ready", bus.cfg_ready, 0);
        check("cfg_type", bus.mg_mask_type, mt);
        check("cfg_pw", bus.mg_pattern_w, pw);
        check("cfg_rep", bus.mg_repeated_pattern, rep);

        nload = (mt == 2'b11) ? 1 : PAT_LEN;
        for (int k = 0; k < nload; k++) begin
            tick();
            if (k == abort_load) bus.abort = 1;
            settle();
            if (k == 0) check("rst_n_one_cycle", bus.mg_rst_n, 1);
            if (k == abort_load) begin
                check("abort_load_strobe", bus.mg_load_pattern, 0);
                aborted = 1;
                break;
            end
            check("load_strobe", bus.mg_load_pattern, 1);
            if (mt != 2'b11) check("load_bit", bus.mg_pattern, pat[k]);
        end

        if (!aborted) begin
            nrows    = 0;
            done_run = 0;
            for (int cyc = 0; cyc < RUN_BUDGET && !done_run; cyc++) begin
                tick();
                case (rr_mode)
                    0:       rr = 1;
                    1:       rr = (cyc % 2 == 0);
                    default: rr = ($urandom_range(0, 1) == 1);
                endcase
                rp = ($urandom_range(0, 9) < 8);
                ab = (abort_row >= 0 && nrows == abort_row);
                if (ab) begin rp = 1; rr = 1; end
                mask = init;
                if (nrows != 0 && nrows != match_row) begin
                    int pos;
                    pos = 32 + $urandom_range(0, 607);
                    mask[pos] = ~mask[pos];
                end
                bus.row_ready = rr; bus.mg_rp_valid = rp; bus.mg_mask = mask; bus.abort = ab;
                settle();
                acc = rp && rr;
                if (mt == 2'b11)      comp = acc;
                else if (mt == 2'b10) comp = acc && (nrows + 1 == FRAME_ROWS);
                else                  comp = acc && ((nrows >= 1 && nrows == match_row) || nrows + 1 == MAX_ROWS);
                if (comp && sliding && nrows != match_row) exp_to = 1;
                check("run_clk_en", bus.mg_clk_en, rr);
                if (cyc == 0) check("run_load_off", bus.mg_load_pattern, 0);
                check("row_valid", bus.row_valid, acc && (comp || !ab));
                if (acc && (comp || !ab)) check("row_index", bus.row_index, nrows);
                if (bus.row_valid) nvalid++;
                if (comp || ab) done_run = 1;
                else if (acc)   nrows++;
            end
            if (!done_run) check("run_budget", 0, 1);
            if (mt == 2'b10 && abort_row < 0) check("random_rows", nvalid, FRAME_ROWS);
            if (mt == 2'b11) check("repeat_rows", nvalid, 1);
        end

        tick();
        bus.abort = 0; bus.mg_rp_valid = 0;
        settle();
        check("frame_done", bus.frame_done, 1);
        check("timeout", bus.timeout, exp_to);
        check("done_clk_en", bus.mg_clk_en, 0);
        check("done_load", bus.mg_load_pattern, 0);
        check("done_row_valid", bus.row_valid, 0);
        check("held_type", bus.mg_mask_type, mt);
        check("held_rep", bus.mg_repeated_pattern, rep);

        tick();
        bus.cfg_valid = 0;
        settle();
        check("ready_after_done", bus.cfg_ready, 1);
        check("frame_done_pulse", bus.frame_done, 0);
        check("timeout_pulse", bus.timeout, 0);
    endtask

    initial begin
        bus.cfg_valid = 0; bus.cfg_mask_type = 0; bus.cfg_pattern_w = 0;
        bus.cfg_repeated_pattern = 0; bus.cfg_pattern = 0; bus.abort = 0;
        bus.row_ready = 0; bus.mg_mask = '0; bus.mg_rp_valid = 0;
        #1 rst = 1;
        bus.cfg_valid = 1; bus.cfg_mask_type = 2'b10; bus.cfg_pattern_w = 5'd7;
        bus.cfg_repeated_pattern = 8'h55;
        #1 check_reset("por");
        repeat (2) tick();
        rst = 0; bus.cfg_valid = 0;
        settle();
        check("post_por_rst_n", bus.mg_rst_n, 1);
        check("post_por_ready", bus.cfg_ready, 1);
        check("post_por_type", bus.mg_mask_type, 0);

        do_frame(2'b11, $urandom, 8'hAF, 5'($urandom), 0, -1, -1, -1);
        do_frame(2'b00, 32'h03D0A052, 8'($urandom), 5'd31, 2, $urandom_range(1, 600), -1, -1);
        do_frame(2'b10, $urandom, 8'($urandom), 5'($urandom), 1, -1, -1, -1);
        do_frame(2'b01, $urandom, 8'($urandom), 5'($urandom), 0, -1, -1, -1);
        do_frame(2'b00, $urandom, 8'($urandom), 5'($urandom), 2, -1, 10, -1);
        do_frame(2'b11, $urandom, 8'h3C, 5'($urandom), 2, -1, -1, -1);
        do_frame(2'b10, $urandom, 8'($urandom), 5'($urandom), 2, -1, -1, 5);
        do_frame(2'b01, $urandom, 8'($urandom), 5'($urandom), 2, 3, -1, 3);

        // reset in the middle of a RUN phase
        tick();
        bus.cfg_valid = 1; bus.cfg_mask_type = 2'b10; bus.cfg_pattern = $urandom;
        bus.cfg_pattern_w = 5'd9; bus.cfg_repeated_pattern = 8'h3C;
        tick();
        bus.cfg_valid = 0; bus.row_ready = 1; bus.mg_rp_valid = 1;
        repeat (40) tick();
        settle();
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_row_valid", bus.row_valid, 1);
        #1 rst = 1; bus.cfg_valid = 1; bus.cfg_mask_type = 2'b01;
        #1 check_reset("mid");
        repeat (2) tick();
        rst = 0; bus.cfg_valid = 0; bus.mg_rp_valid = 0;
        settle();
        check("post_mid_rst_n", bus.mg_rst_n, 1);
        check("post_mid_ready", bus.cfg_ready, 1);
        check("post_mid_busy", bus.busy, 0);
        check("post_mid_type", bus.mg_mask_type, 0);

        do_frame(2'b11, $urandom, 8'h81, 5'($urandom), 2, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
